// File: rtl/fc_event_router.sv
// fc_event_router
// Latches single-cycle event pulses from NB_SOURCES peripherals as pending
// bits, serialises them with a round-robin arbiter into a small local FIFO,
// and presents the FIFO head to the fabric controller's event port.
//
// Ports:
//   clk_i               clock
//   rst_i               asynchronous active-high reset
//   src_event_i         one-cycle event pulses, one bit per source
//   src_mask_i          1 = ignore new pulses from that source
//   event_fifo_valid_o  FIFO head is valid
//   event_fifo_fulln_i  consumer can accept (1 = not full)
//   event_fifo_data_o   event ID at the FIFO head
//   lost_o              one-cycle pulse: at least one event was dropped
//   lost_id_o           ID of the lowest-index dropped event (valid with lost_o)
//   lost_cnt_o          saturating count of dropped events
//   pending_o           pending bit vector
module fc_event_router #(
  parameter int NB_SOURCES     = 16,
  parameter int EVENT_ID_WIDTH = 8,
  parameter int ID_BASE        = 0,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [NB_SOURCES-1:0]     src_event_i,
  input  logic [NB_SOURCES-1:0]     src_mask_i,
  output logic                      event_fifo_valid_o,
  input  logic                      event_fifo_fulln_i,
  output logic [EVENT_ID_WIDTH-1:0] event_fifo_data_o,
  output logic                      lost_o,
  output logic [EVENT_ID_WIDTH-1:0] lost_id_o,
  output logic [15:0]               lost_cnt_o,
  output logic [NB_SOURCES-1:0]     pending_o
);

  localparam int IDXW = $clog2(NB_SOURCES);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int DCW  = $clog2(NB_SOURCES + 1);

  if (ID_BASE + NB_SOURCES - 1 >= (1 << EVENT_ID_WIDTH)) begin : g_id_range_check
    $error("fc_event_router: ID_BASE+NB_SOURCES-1 does not fit in EVENT_ID_WIDTH");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("fc_event_router: FIFO_DEPTH must be a power of two >= 2");
  end

  function automatic logic [EVENT_ID_WIDTH-1:0] idOf(input logic [IDXW-1:0] idx);
    return EVENT_ID_WIDTH'(ID_BASE + int'(idx));
  endfunction

  logic [NB_SOURCES-1:0]     pending_q, pending_d;
  logic [IDXW-1:0]           last_grant_q, last_grant_d;
  logic [EVENT_ID_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [PTRW-1:0]           wr_ptr_q, rd_ptr_q;
  logic [PTRW:0]             count_q, count_d;
  logic                      lost_q, lost_d;
  logic [EVENT_ID_WIDTH-1:0] lost_id_q, lost_id_d;
  logic [15:0]               lost_cnt_q, lost_cnt_d;

  logic                  can_grant;
  logic                  grant_valid;
  logic [IDXW-1:0]       grant_idx;
  logic [NB_SOURCES-1:0] grant_vec, set_vec, drop_vec;
  logic [DCW-1:0]        drop_count;
  logic [IDXW-1:0]       low_idx;
  logic [16:0]           lost_sum;
  logic                  push, pop;

  // Conservative full rule: a full FIFO blocks grants even if it pops this cycle.
  assign can_grant = (count_q != (PTRW+1)'(FIFO_DEPTH));
  assign pop       = (count_q != '0) && event_fifo_fulln_i;
  assign push      = grant_valid;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= NB_SOURCES; k++) begin
      if (!grant_valid && can_grant &&
          pending_q[(int'(last_grant_q) + k) % NB_SOURCES]) begin
        grant_valid = 1'b1;
        grant_idx   = IDXW'((int'(last_grant_q) + k) % NB_SOURCES);
      end
    end
  end

  // A pulse on a bit that is being granted this cycle re-arms it instead of
  // being dropped.
  always_comb begin
    set_vec   = src_event_i & ~src_mask_i;
    grant_vec = '0;
    if (grant_valid) grant_vec[grant_idx] = 1'b1;
    drop_vec  = set_vec & pending_q & ~grant_vec;
    pending_d = (pending_q & ~grant_vec) | set_vec;

    drop_count = '0;
    low_idx    = '0;
    for (int i = NB_SOURCES - 1; i >= 0; i--) begin
      drop_count = drop_count + DCW'(drop_vec[i]);
      if (drop_vec[i]) low_idx = IDXW'(i);
    end

    lost_d     = |drop_vec;
    lost_id_d  = lost_d ? idOf(low_idx) : '0;
    lost_sum   = {1'b0, lost_cnt_q} + 17'(drop_count);
    lost_cnt_d = lost_sum[16] ? 16'hFFFF : lost_sum[15:0];

    last_grant_d = grant_valid ? grant_idx : last_grant_q;

    count_d = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (!push && pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q    <= '0;
      last_grant_q <= IDXW'(NB_SOURCES - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      lost_q       <= 1'b0;
      lost_id_q    <= '0;
      lost_cnt_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      pending_q    <= pending_d;
      last_grant_q <= last_grant_d;
      count_q      <= count_d;
      lost_q       <= lost_d;
      lost_id_q    <= lost_id_d;
      lost_cnt_q   <= lost_cnt_d;
      if (push) begin
        fifo_q[wr_ptr_q] <= idOf(grant_idx);
        wr_ptr_q         <= wr_ptr_q + PTRW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTRW'(1);
    end
  end

  assign event_fifo_valid_o = (count_q != '0);
  assign event_fifo_data_o  = fifo_q[rd_ptr_q];
  assign lost_o             = lost_q;
  assign lost_id_o          = lost_id_q;
  assign lost_cnt_o         = lost_cnt_q;
  assign pending_o          = pending_q;

endmodule

// File: tb/tb_fc_event_router.sv
// tb_fc_event_router
// Directed scenarios plus a randomised phase for fc_event_router, checked
// cycle by cycle against a queue-based behavioural model of the router.
module tb_fc_event_router;

  localparam int N    = 16;
  localparam int W    = 8;
  localparam int BASE = 0;
  localparam int D    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  srcEvent = '0;
  logic [N-1:0]  srcMask  = '0;
  logic          fulln    = 1'b1;
  logic          valid;
  logic [W-1:0]  data;
  logic          lost;
  logic [W-1:0]  lostId;
  logic [15:0]   lostCnt;
  logic [N-1:0]  pending;

  int testsRun  = 0;
  int failCount = 0;

  // Behavioural model state
  bit pendM [N];
  int lastGrantM;
  int fifoM [$];
  bit lostM;
  int lostIdM;
  int lostCntM;

  fc_event_router #(
    .NB_SOURCES(N), .EVENT_ID_WIDTH(W), .ID_BASE(BASE), .FIFO_DEPTH(D)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .src_event_i(srcEvent),
    .src_mask_i(srcMask),
    .event_fifo_valid_o(valid),
    .event_fifo_fulln_i(fulln),
    .event_fifo_data_o(data),
    .lost_o(lost),
    .lost_id_o(lostId),
    .lost_cnt_o(lostCnt),
    .pending_o(pending)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    testsRun++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < N; i++) pendM[i] = 1'b0;
    lastGrantM = N - 1;
    fifoM.delete();
    lostM    = 1'b0;
    lostIdM  = 0;
    lostCntM = 0;
  endtask

  // One clock edge of the router, from the rules for pending, arbitration,
  // FIFO occupancy and drop accounting.
  task automatic modelStep(input logic [N-1:0] ev, input logic [N-1:0] mask, input logic fl);
    int  g      = -1;
    int  lowest = -1;
    int  nDrop  = 0;
    bit  popNow = (fifoM.size() != 0) && fl;
    if (fifoM.size() < D) begin
      for (int k = 1; k <= N; k++) begin
        int j = (lastGrantM + k) % N;
        if (g < 0 && pendM[j]) g = j;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (ev[i] && !mask[i] && pendM[i] && i != g) begin
        nDrop++;
        if (lowest < 0) lowest = i;
      end
    end
    if (g >= 0) begin
      pendM[g]   = 1'b0;
      lastGrantM = g;
    end
    for (int i = 0; i < N; i++) if (ev[i] && !mask[i]) pendM[i] = 1'b1;
    if (popNow) void'(fifoM.pop_front());
    if (g >= 0) fifoM.push_back(BASE + g);
    lostM    = (nDrop > 0);
    lostIdM  = (nDrop > 0) ? BASE + lowest : 0;
    lostCntM = (lostCntM + nDrop > 65535) ? 65535 : lostCntM + nDrop;
  endtask

  task automatic checkOutput();
    logic [N-1:0] pv;
    for (int i = 0; i < N; i++) pv[i] = pendM[i];
    checkVal("valid", 64'(valid), 64'(fifoM.size() != 0));
    if (fifoM.size() != 0) checkVal("data", 64'(data), 64'(fifoM[0]));
    checkVal("lost", 64'(lost), 64'(lostM));
    if (lostM) checkVal("lostId", 64'(lostId), 64'(lostIdM));
    checkVal("lostCnt", 64'(lostCnt), 64'(lostCntM));
    checkVal("pending", 64'(pending), 64'(pv));
  endtask

  // Drive one cycle of inputs, step the model on the edge, check just after it.
  task automatic applyStimulus(input logic [N-1:0] ev, input logic [N-1:0] mask, input logic fl);
    srcEvent = ev;
    srcMask  = mask;
    fulln    = fl;
    @(posedge clk);
    modelStep(ev, mask, fl);
    #1;
    checkOutput();
  endtask

  task automatic checkAllZero(input string tag);
    checkVal({tag, "_valid"},   64'(valid),   64'd0);
    checkVal({tag, "_data"},    64'(data),    64'd0);
    checkVal({tag, "_lost"},    64'(lost),    64'd0);
    checkVal({tag, "_lostId"},  64'(lostId),  64'd0);
    checkVal({tag, "_lostCnt"}, 64'(lostCnt), 64'd0);
    checkVal({tag, "_pending"}, 64'(pending), 64'd0);
  endtask

  task automatic doReset();
    srcEvent = '0;
    srcMask  = '0;
    fulln    = 1'b1;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    modelReset();
  endtask

  initial begin
    int rrExp1 [3] = '{0, 3, 9};
    int rrExp2 [2] = '{0, 3};
    int seen7;
    bit saw4;

    modelReset();
    doReset();

    // Single event on source 5: pending one cycle, then valid with ID 5 for one cycle
    applyStimulus(16'h0020, '0, 1'b1);
    checkVal("single_pend1", 64'(pending), 64'h20);
    checkVal("single_valid1", 64'(valid), 64'd0);
    applyStimulus('0, '0, 1'b1);
    checkVal("single_valid2", 64'(valid), 64'd1);
    checkVal("single_data2", 64'(data), 64'h05);
    checkVal("single_pend2", 64'(pending), 64'd0);
    applyStimulus('0, '0, 1'b1);
    checkVal("single_valid3", 64'(valid), 64'd0);

    // Round-robin ordering and wrap-around from last grant
    doReset();
    applyStimulus(16'h0209, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus('0, '0, 1'b1);
      checkVal("rr1_valid", 64'(valid), 64'd1);
      checkVal("rr1_data", 64'(data), 64'(rrExp1[i]));
    end
    applyStimulus('0, '0, 1'b1);
    applyStimulus('0, '0, 1'b1);
    applyStimulus(16'h0009, '0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      applyStimulus('0, '0, 1'b1);
      checkVal("rr2_data", 64'(data), 64'(rrExp2[i]));
    end

    // Backpressure fills the FIFO, remaining sources stay pending
    doReset();
    applyStimulus(16'h003F, '0, 1'b0);
    for (int i = 0; i < 6; i++) applyStimulus('0, '0, 1'b0);
    checkVal("bp_pending", 64'(pending), 64'h0030);
    checkVal("bp_valid", 64'(valid), 64'd1);
    checkVal("bp_data", 64'(data), 64'h00);
    for (int i = 0; i < 8; i++) applyStimulus('0, '0, 1'b1);
    checkVal("bp_drained", 64'(valid), 64'd0);
    checkVal("bp_nolost", 64'(lostCnt), 64'd0);

    // Drops on a stuck pending bit
    doReset();
    applyStimulus(16'h008F, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus('0, '0, 1'b0);
    applyStimulus(16'h0080, '0, 1'b0);
    checkVal("drop1_lost", 64'(lost), 64'd1);
    checkVal("drop1_id", 64'(lostId), 64'h07);
    checkVal("drop1_cnt", 64'(lostCnt), 64'd1);
    applyStimulus('0, '0, 1'b0);
    checkVal("drop_pulse_end", 64'(lost), 64'd0);
    applyStimulus(16'h0080, '0, 1'b0);
    checkVal("drop2_id", 64'(lostId), 64'h07);
    checkVal("drop2_cnt", 64'(lostCnt), 64'd2);
    seen7 = 0;
    for (int i = 0; i < 10; i++) begin
      if (valid && data == 8'h07) seen7++;
      applyStimulus('0, '0, 1'b1);
    end
    checkVal("drop_one7", 64'(seen7), 64'd1);

    // Counter saturation under sustained multi-source drops
    for (int i = 0; i < 4200; i++) applyStimulus({N{1'b1}}, '0, 1'b0);
    checkVal("sat_cnt", 64'(lostCnt), 64'hFFFF);
    for (int i = 0; i < 30; i++) applyStimulus('0, '0, 1'b1);
    checkVal("sat_hold", 64'(lostCnt), 64'hFFFF);

    // Masking blocks new sets but not already pending bits
    doReset();
    applyStimulus(16'h0004, 16'h0004, 1'b1);
    checkVal("mask_pend", 64'(pending), 64'd0);
    for (int i = 0; i < 3; i++) applyStimulus('0, 16'h0004, 1'b1);
    checkVal("mask_none", 64'(valid), 64'd0);
    checkVal("mask_nolost", 64'(lostCnt), 64'd0);
    applyStimulus(16'h001F, '0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus('0, '0, 1'b0);
    checkVal("mask4_pend", 64'(pending), 64'h0010);
    saw4 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus('0, 16'h0010, 1'b1);
      if (valid && data == 8'h04) saw4 = 1'b1;
    end
    checkVal("mask4_delivered", 64'(saw4), 64'd1);

    // Asynchronous reset in the middle of traffic
    doReset();
    applyStimulus(16'h0007, '0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0);
    applyStimulus(16'h00F0, '0, 1'b0);
    checkVal("mid_pend", 64'(pending), 64'h00F0);
    #2;
    srcEvent = '0;
    rst = 1'b1;
    #1;
    checkAllZero("midreset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    modelReset();
    for (int i = 0; i < 4; i++) applyStimulus('0, '0, 1'b1);
    checkVal("mid_quiet", 64'(valid), 64'd0);
    applyStimulus(16'h0001, '0, 1'b1);
    applyStimulus('0, '0, 1'b1);
    checkVal("mid_next_valid", 64'(valid), 64'd1);
    checkVal("mid_next_data", 64'(data), 64'h00);

    // Randomised traffic against the model
    doReset();
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] ev;
      logic [N-1:0] mk;
      ev = N'($urandom & $urandom & $urandom);
      mk = N'($urandom & $urandom);
      applyStimulus(ev, mk, $urandom_range(0, 3) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
